// File: rtl/algn_pkg.sv
// Shared definitions for the byte aligner: default beat geometry, beat structs and the
// alignment legality rule used for both RX beats and the TX configuration.
package algn_pkg;

    localparam int ALGN_DW_DEF  = 32;
    localparam int BYTES_W_DEF  = ALGN_DW_DEF / 8;

    function automatic int ow_of(input int bytes_w);
        return (bytes_w > 1) ? $clog2(bytes_w) : 1;
    endfunction

    function automatic int sw_of(input int bytes_w);
        return $clog2(bytes_w) + 1;
    endfunction

    localparam int OW_DEF = ow_of(BYTES_W_DEF);
    localparam int SW_DEF = sw_of(BYTES_W_DEF);

    typedef struct packed {
        logic [ALGN_DW_DEF-1:0] data;
        logic [OW_DEF-1:0]      offset;
        logic [SW_DEF-1:0]      size;
    } rx_beat_t;

    typedef struct packed {
        logic [ALGN_DW_DEF-1:0] data;
        logic [OW_DEF-1:0]      offset;
        logic [SW_DEF-1:0]      size;
    } tx_beat_t;

    // Size zero is rejected before the modulo so the divisor is never zero.
    function automatic logic is_align_valid(input int bytes_w, input int off, input int sz);
        logic ok;
        ok = 1'b0;
        if ((sz >= 1) && (sz <= bytes_w) && (off < bytes_w)) begin
            ok = (((bytes_w + off) % sz) == 0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/algn_byte_fifo.sv
// Circular byte buffer: up to BYTES_W bytes pushed and popped per cycle, with a
// combinational peek of the next BYTES_W bytes at the read pointer.
module algn_byte_fifo
    import algn_pkg::*;
#(
    parameter int BYTES_W = 4,
    parameter int DEPTH   = 16,
    parameter int SW      = 3,
    parameter int LW      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [SW-1:0]        push_cnt,
    input  logic [8*BYTES_W-1:0] push_data,
    input  logic [SW-1:0]        pop_cnt,
    output logic [8*BYTES_W-1:0] pop_data,
    output logic [LW-1:0]        level
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < BYTES_W; i++) begin
            if (i < int'(push_cnt)) begin
                mem_d[wr_ptr_q + PW'(i)] = push_data[8*i +: 8];
            end
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_cnt);
            rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
            level_d  = level_q + LW'(push_cnt) - LW'(pop_cnt);
        end
    end

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < BYTES_W; i++) begin
            pop_data[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign level = level_q;

endmodule

// File: rtl/algn_byte_repacker.sv
// Aligner core: filters illegal RX beats, buffers valid bytes and re-packs them into TX
// beats of the configured size at the configured byte offset.
module algn_byte_repacker
    import algn_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH_BYTES = 16,
    parameter int CNT_WIDTH        = 16,
    localparam int BYTES_W = ALGN_DATA_WIDTH / 8,
    localparam int OW      = ow_of(BYTES_W),
    localparam int SW      = sw_of(BYTES_W),
    localparam int LW      = $clog2(FIFO_DEPTH_BYTES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [SW-1:0]              cfg_size,
    input  logic [OW-1:0]              cfg_offset,
    input  logic                       rx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0] rx_data,
    input  logic [OW-1:0]              rx_offset,
    input  logic [SW-1:0]              rx_size,
    output logic                       rx_ready,
    output logic                       rx_err,
    output logic                       tx_valid,
    output logic [ALGN_DATA_WIDTH-1:0] tx_data,
    output logic [OW-1:0]              tx_offset,
    output logic [SW-1:0]              tx_size,
    input  logic                       tx_ready,
    output logic                       cfg_err,
    output logic [LW-1:0]              buf_level,
    output logic [CNT_WIDTH-1:0]       drop_cnt
);

    logic [LW-1:0]              level;
    logic [ALGN_DATA_WIDTH-1:0] push_data;
    logic [ALGN_DATA_WIDTH-1:0] pop_data;
    logic [ALGN_DATA_WIDTH-1:0] placed;
    logic [SW-1:0]              push_cnt;
    logic [SW-1:0]              pop_cnt;
    logic                       rx_fire;
    logic                       rx_legal;
    logic                       load;

    logic                       rx_err_q, rx_err_d;
    logic                       tx_valid_q, tx_valid_d;
    logic [ALGN_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [OW-1:0]              tx_offset_q, tx_offset_d;
    logic [SW-1:0]              tx_size_q, tx_size_d;
    logic [CNT_WIDTH-1:0]       drop_cnt_q, drop_cnt_d;

    algn_byte_fifo #(
        .BYTES_W (BYTES_W),
        .DEPTH   (FIFO_DEPTH_BYTES),
        .SW      (SW),
        .LW      (LW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .pop_data  (pop_data),
        .level     (level)
    );

    // RX side: readiness depends only on free space, so a full beat always fits.
    always_comb begin
        rx_ready  = ((LW'(FIFO_DEPTH_BYTES) - level) >= LW'(BYTES_W)) && !flush;
        rx_legal  = is_align_valid(BYTES_W, int'(rx_offset), int'(rx_size));
        cfg_err   = !is_align_valid(BYTES_W, int'(cfg_offset), int'(cfg_size));
        rx_fire   = rx_valid && rx_ready;
        push_cnt  = (rx_fire && rx_legal) ? rx_size : '0;
        push_data = rx_data >> (8 * int'(rx_offset));
    end

    // TX side: load uses the pre-push level, giving a two-cycle accept-to-valid latency.
    always_comb begin
        load    = (!tx_valid_q || tx_ready) && !cfg_err && (level >= LW'(cfg_size)) && !flush;
        pop_cnt = load ? cfg_size : '0;
        placed  = '0;
        for (int i = 0; i < BYTES_W; i++) begin
            if (i < int'(cfg_size)) begin
                placed[8*i +: 8] = pop_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        tx_offset_d = tx_offset_q;
        tx_size_d   = tx_size_q;
        if (flush) begin
            tx_valid_d = 1'b0;
        end else if (load) begin
            tx_valid_d  = 1'b1;
            tx_data_d   = placed << (8 * int'(cfg_offset));
            tx_offset_d = cfg_offset;
            tx_size_d   = cfg_size;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end

        rx_err_d   = rx_fire && !rx_legal;
        drop_cnt_d = drop_cnt_q;
        if (rx_err_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_err_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_offset_q <= '0;
            tx_size_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rx_err_q    <= rx_err_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_offset_q <= tx_offset_d;
            tx_size_q   <= tx_size_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rx_err    = rx_err_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_offset = tx_offset_q;
    assign tx_size   = tx_size_q;
    assign buf_level = level;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_algn_byte_repacker.sv
// Bench for algn_byte_repacker: byte-queue reference model, per-cycle compare process,
// directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_algn_byte_repacker;

    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  cfg_size;
    logic [1:0]  cfg_offset;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic [1:0]  rx_offset;
    logic [2:0]  rx_size;
    logic        rx_ready;
    logic        rx_err;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [1:0]  tx_offset;
    logic [2:0]  tx_size;
    logic        tx_ready;
    logic        cfg_err;
    logic [4:0]  buf_level;
    logic [15:0] drop_cnt;

    algn_byte_repacker #(
        .ALGN_DATA_WIDTH  (32),
        .FIFO_DEPTH_BYTES (DEPTH),
        .CNT_WIDTH        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .cfg_size   (cfg_size),
        .cfg_offset (cfg_offset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_offset  (rx_offset),
        .rx_size    (rx_size),
        .rx_ready   (rx_ready),
        .rx_err     (rx_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_offset  (tx_offset),
        .tx_size    (tx_size),
        .tx_ready   (tx_ready),
        .cfg_err    (cfg_err),
        .buf_level  (buf_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int off, input int sz);
        if (sz < 1 || sz > BW || off >= BW) return 1'b0;
        return ((BW + off) % sz) == 0;
    endfunction

    // Reference model: the buffer is a plain byte queue, the TX beat a record.
    logic [7:0]  mq[$];
    bit          m_tx_valid;
    logic [31:0] m_tx_data;
    int          m_tx_off;
    int          m_tx_size;
    bit          m_rx_err;
    int          m_drop;
    int          m_lvl;
    bit          m_fire;
    logic [7:0]  m_b;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_tx_valid = 1'b0;
            m_tx_data  = '0;
            m_tx_off   = 0;
            m_tx_size  = 0;
            m_rx_err   = 1'b0;
            m_drop     = 0;
        end else begin
            m_lvl  = mq.size();
            m_fire = rx_valid && ((DEPTH - m_lvl) >= BW) && !flush;
            if (flush) begin
                mq.delete();
                m_tx_valid = 1'b0;
                m_rx_err   = 1'b0;
            end else begin
                if ((!m_tx_valid || tx_ready) && legal(cfg_offset, cfg_size) && m_lvl >= cfg_size) begin
                    m_tx_data = '0;
                    for (int i = 0; i < int'(cfg_size); i++) begin
                        m_b = mq.pop_front();
                        if (int'(cfg_offset) + i < BW) m_tx_data[8*(int'(cfg_offset)+i) +: 8] = m_b;
                    end
                    m_tx_valid = 1'b1;
                    m_tx_off   = cfg_offset;
                    m_tx_size  = cfg_size;
                end else if (tx_ready) begin
                    m_tx_valid = 1'b0;
                end
                m_rx_err = m_fire && !legal(rx_offset, rx_size);
                if (m_fire && legal(rx_offset, rx_size)) begin
                    for (int i = 0; i < int'(rx_size); i++) begin
                        if (int'(rx_offset) + i < BW) mq.push_back(rx_data[8*(int'(rx_offset)+i) +: 8]);
                        else mq.push_back(8'h00);
                    end
                end
                if (m_rx_err && m_drop < 65535) m_drop++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("tx_valid", tx_valid, m_tx_valid);
            if (m_tx_valid) begin
                chk("tx_data", tx_data, m_tx_data);
                chk("tx_offset", tx_offset, m_tx_off);
                chk("tx_size", tx_size, m_tx_size);
            end
            chk("buf_level", buf_level, mq.size());
            chk("rx_ready", rx_ready, ((DEPTH - mq.size()) >= BW) && !flush);
            chk("rx_err", rx_err, m_rx_err);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("cfg_err", cfg_err, !legal(cfg_offset, cfg_size));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] off, input logic [2:0] sz);
        rx_valid  = 1'b1;
        rx_data   = d;
        rx_offset = off;
        rx_size   = sz;
    endtask

    logic [31:0] held;

    initial begin
        reset = 1'b1; flush = 1'b0; cfg_size = 3'd4; cfg_offset = 2'd0;
        rx_valid = 1'b0; rx_data = '0; rx_offset = '0; rx_size = '0; tx_ready = 1'b1;
        tick(); tick();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_level", buf_level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_rx_ready", rx_ready, 1);
        reset = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Basic 4/0 pass-through and latency
        send(32'hDDCCBBAA, 2'd0, 3'd4);
        tick(); rx_valid = 1'b0;
        chk("t1_lat_valid0", tx_valid, 0);
        chk("t1_level4", buf_level, 4);
        tick();
        chk("t1_valid", tx_valid, 1);
        chk("t1_data", tx_data, 32'hDDCCBBAA);
        chk("t1_off", tx_offset, 0);
        chk("t1_size", tx_size, 4);
        tick();
        chk("t1_drained", tx_valid, 0);

        // Split into two 2-byte beats at offset 2
        cfg_size = 3'd2; cfg_offset = 2'd2;
        send(32'h44332211, 2'd0, 3'd4);
        tick(); rx_valid = 1'b0;
        tick();
        chk("t2_data0", tx_data, 32'h22110000);
        chk("t2_off0", tx_offset, 2);
        tick();
        chk("t2_data1", tx_data, 32'h44330000);
        chk("t2_size1", tx_size, 2);
        tick();

        // Illegal RX beat
        send(32'h12345678, 2'd1, 3'd2);
        tick(); rx_valid = 1'b0;
        chk("t3_rx_err", rx_err, 1);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_level", buf_level, 0);
        tick();
        chk("t3_err_pulse", rx_err, 0);
        chk("t3_no_tx", tx_valid, 0);

        // Illegal cfg holds bytes; then 1/3 emits one byte per beat in the top lane
        cfg_size = 3'd3; cfg_offset = 2'd0;
        #1 chk("t5_cfg_err", cfg_err, 1);
        send(32'h04030201, 2'd0, 3'd4);
        tick(); rx_valid = 1'b0;
        tick(); tick();
        chk("t5_held_level", buf_level, 4);
        chk("t5_no_tx", tx_valid, 0);
        cfg_size = 3'd1; cfg_offset = 2'd3;
        tick();
        chk("t5_b0", tx_data, 32'h01000000);
        chk("t5_off", tx_offset, 3);
        tick();
        chk("t5_b1", tx_data, 32'h02000000);
        tick(); tick(); tick();

        // Backpressure: fill the buffer while TX is stalled, then drain
        cfg_size = 3'd4; cfg_offset = 2'd0; tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(32'h11111111 * (k + 1), 2'd0, 3'd4);
            tick();
        end
        chk("t4_full_level", buf_level, 16);
        chk("t4_rx_ready0", rx_ready, 0);
        chk("t4_held_data", tx_data, 32'h11111111);
        held = tx_data;
        tick(); tick();
        chk("t4_stable", tx_data, held);
        rx_valid = 1'b0; tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t4_empty", buf_level, 0);

        // Flush with level 6 and a held beat
        tx_ready = 1'b0;
        send(32'hA3A2A1A0, 2'd0, 3'd4); tick();
        send(32'hB3B2B1B0, 2'd0, 3'd4); tick();
        send(32'hC3C2C1C0, 2'd0, 3'd2); tick();
        rx_valid = 1'b0;
        chk("t6_level6", buf_level, 6);
        chk("t6_valid", tx_valid, 1);
        flush = 1'b1;
        send(32'hEEEEEEEE, 2'd0, 3'd4);
        #1 chk("t6_rdy_flush", rx_ready, 0);
        tick();
        flush = 1'b0; rx_valid = 1'b0;
        chk("t6_flush_level", buf_level, 0);
        chk("t6_flush_valid", tx_valid, 0);
        tx_ready = 1'b1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                cfg_offset = 2'($urandom_range(0, 3));
                cfg_size   = 3'($urandom_range(1, 4));
            end
            rx_valid  = ($urandom_range(0, 1) == 1);
            rx_data   = $urandom;
            rx_offset = 2'($urandom_range(0, 3));
            rx_size   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'd4 - 3'(rx_offset);
            tx_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;

        // Async reset mid-beat
        cfg_size = 3'd4; cfg_offset = 2'd0; tx_ready = 1'b0;
        send(32'h55555555, 2'd1, 3'd2); tick();
        send(32'h66666666, 2'd0, 3'd4); tick();
        send(32'h77777777, 2'd0, 3'd4); tick();
        rx_valid = 1'b0;
        tick();
        chk("t7_pre_valid", tx_valid, 1);
        chk("t7_pre_drop_nz", drop_cnt != 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("t7_rst_valid", tx_valid, 0);
        chk("t7_rst_data", tx_data, 0);
        chk("t7_rst_off", tx_offset, 0);
        chk("t7_rst_size", tx_size, 0);
        chk("t7_rst_level", buf_level, 0);
        chk("t7_rst_drop", drop_cnt, 0);
        chk("t7_rst_err", rx_err, 0);
        chk("t7_rst_ready", rx_ready, 1);
        tick();
        reset = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
